mod12_display_driver: RTL and testbench

Downstream consumer of the mod-12 counter: samples its 4-bit `count` (0–11) and drives a three-digit multiplexed seven-segment display showing the 12-hour value (count 0 shown as "12"), plus an A/P indicator digit. The driver detects natural 11→0 roll-over to toggle AM/PM and emit a wrap pulse. It distinguishes roll-over from preset loads, and flags out-of-range counts.

---
 rtl/mod12_disp_pkg.sv | 33 +++
 rtl/seg7_encoder.sv | 29 ++
 rtl/mod12_display_driver.sv | 119 +++++++++++
 tb/tb_mod12_display_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mod12_disp_pkg.sv
// Shared types and constants for the mod-12 clock display driver.
package mod12_disp_pkg;

    typedef enum logic [1:0] {
        TENS = 2'd0,
        ONES = 2'd1,
        AP   = 2'd2
    } scan_state_t;

    localparam logic [3:0] MAX_COUNT = 4'd11;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Symbol codes fed to the encoder: 0-9 are decimal digits.
    localparam logic [4:0] SYM_A     = 5'd10;
    localparam logic [4:0] SYM_P     = 5'd11;
    localparam logic [4:0] SYM_DASH  = 5'd12;
    localparam logic [4:0] SYM_BLANK = 5'd13;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational symbol-code to seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_encoder
    import mod12_disp_pkg::*;
(
    input  logic [4:0] sym,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (sym)
            5'd0:     seg = SEG_0;
            5'd1:     seg = SEG_1;
            5'd2:     seg = SEG_2;
            5'd3:     seg = SEG_3;
            5'd4:     seg = SEG_4;
            5'd5:     seg = SEG_5;
            5'd6:     seg = SEG_6;
            5'd7:     seg = SEG_7;
            5'd8:     seg = SEG_8;
            5'd9:     seg = SEG_9;
            SYM_A:    seg = SEG_A;
            SYM_P:    seg = SEG_P;
            SYM_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mod12_display_driver.sv
// Samples the mod-12 counter and drives a 3-digit multiplexed display
// (12-hour value plus A/P), with roll-over detection and a sticky range error.
module mod12_display_driver
    import mod12_disp_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       load,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       pm,
    output logic       wrap,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       cnt_q;
    logic             load_q;
    logic [DIV_W-1:0] div_q;
    scan_state_t      state_q;

    logic       rollover;
    logic [4:0] tens_sym;
    logic [4:0] ones_sym;
    logic [4:0] cur_sym;
    logic [6:0] seg_next;

    // A load on the previous edge means an 11->0 step is a preset, not a wrap.
    assign rollover  = (cnt_q == MAX_COUNT) && (count == 4'd0) && !load_q;
    assign dbg_state = state_q;

    always_comb begin
        tens_sym = SYM_BLANK;
        ones_sym = SYM_BLANK;
        if (err) begin
            tens_sym = SYM_DASH;
            ones_sym = SYM_DASH;
        end else begin
            case (cnt_q)
                4'd0:  begin tens_sym = 5'd1; ones_sym = 5'd2; end
                4'd10: begin tens_sym = 5'd1; ones_sym = 5'd0; end
                4'd11: begin tens_sym = 5'd1; ones_sym = 5'd1; end
                default: begin
                    tens_sym = SYM_BLANK;
                    ones_sym = (cnt_q <= 4'd9) ? {1'b0, cnt_q} : SYM_BLANK;
                end
            endcase
        end
    end

    always_comb begin
        cur_sym = SYM_BLANK;
        case (state_q)
            TENS:    cur_sym = tens_sym;
            ONES:    cur_sym = ones_sym;
            AP:      cur_sym = pm ? SYM_P : SYM_A;
            default: cur_sym = SYM_BLANK;
        endcase
    end

    seg7_encoder u_enc (
        .sym (cur_sym),
        .seg (seg_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 4'd0;
            load_q <= 1'b0;
            pm     <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt_q  <= count;
            load_q <= load;
            wrap   <= rollover;
            if (rollover)
                pm <= ~pm;
            if (count > MAX_COUNT)
                err <= 1'b1;
        end
    end

    // Scan FSM: seg/an are registered from the state current at each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            state_q <= TENS;
            seg     <= SEG_BLANK;
            an      <= 3'b001;
        end else begin
            seg <= seg_next;
            case (state_q)
                TENS:    an <= 3'b001;
                ONES:    an <= 3'b010;
                AP:      an <= 3'b100;
                default: an <= 3'b001;
            endcase
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                case (state_q)
                    TENS:    state_q <= ONES;
                    ONES:    state_q <= AP;
                    AP:      state_q <= TENS;
                    default: state_q <= TENS;
                endcase
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod12_display_driver.sv
// Directed bench for mod12_display_driver with a time-based reference model.
module tb_mod12_display_driver;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd0;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       pm;
    logic       wrap;
    logic       err;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mod12_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .load      (load),
        .seg       (seg),
        .an        (an),
        .pm        (pm),
        .wrap      (wrap),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         m_cnt  = 0;
    bit         m_load = 1'b0;
    bit         m_pm   = 1'b0;
    bit         m_wrap = 1'b0;
    bit         m_err  = 1'b0;
    int         m_n    = 0;
    logic [6:0] m_seg  = 7'h00;
    logic [2:0] m_an   = 3'b001;

    function automatic logic [6:0] exp_digit(int d, int c, bit e, bit p);
        int hour;
        if (d == 2) return p ? 7'h73 : 7'h77;
        if (e) return 7'h40;
        if (c > 11) return 7'h00;
        hour = (c == 0) ? 12 : c;
        if (d == 0) return (hour >= 10) ? seg_tab[hour / 10] : 7'h00;
        return seg_tab[hour % 10];
    endfunction

    always @(posedge clk or negedge rst) begin
        int d;
        if (!rst) begin
            m_cnt = 0; m_load = 1'b0; m_pm = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
            m_n = 0; m_seg = 7'h00; m_an = 3'b001;
        end else begin
            d = (m_n / SCAN_DIV) % 3;
            m_seg = exp_digit(d, m_cnt, m_err, m_pm);
            m_an = 3'(1 << d);
            m_wrap = (m_cnt == 11) && (count == 4'd0) && !m_load;
            if (m_wrap) m_pm = ~m_pm;
            if (count > 4'd11) m_err = 1'b1;
            m_cnt = int'(count);
            m_load = load;
            m_n++;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", {1'b0, seg}, {1'b0, m_seg});
            check("model_an", {5'b0, an}, {5'b0, m_an});
            check("model_pm", {7'b0, pm}, {7'b0, m_pm});
            check("model_wrap", {7'b0, wrap}, {7'b0, m_wrap});
            check("model_err", {7'b0, err}, {7'b0, m_err});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] c, input logic l, input int cycles);
        count = c;
        load = l;
        repeat (cycles) @(negedge clk);
    endtask

    // Checks one aligned frame of 3*SCAN_DIV cycles against literal digits.
    task automatic frame_check(input logic [6:0] t, input logic [6:0] o, input logic [6:0] a);
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (i < SCAN_DIV) begin
                check("lit_tens_seg", {1'b0, seg}, {1'b0, t});
                check("lit_tens_an", {5'b0, an}, 8'h01);
            end else if (i < 2 * SCAN_DIV) begin
                check("lit_ones_seg", {1'b0, seg}, {1'b0, o});
                check("lit_ones_an", {5'b0, an}, 8'h02);
            end else begin
                check("lit_ap_seg", {1'b0, seg}, {1'b0, a});
                check("lit_ap_an", {5'b0, an}, 8'h04);
            end
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_seg"}, {1'b0, seg}, 8'h00);
        check({tag, "_an"}, {5'b0, an}, 8'h01);
        check({tag, "_pm"}, {7'b0, pm}, 8'h00);
        check({tag, "_wrap"}, {7'b0, wrap}, 8'h00);
        check({tag, "_err"}, {7'b0, err}, 8'h00);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        chk_en = 1'b1;
        rst = 1'b1;

        // Edges 1-12: "12" AM after reset.
        frame_check(7'h06, 7'h5B, 7'h77);

        // Count 9: after two edges of latency, edges 25-36 show " 9A".
        drive(4'd9, 1'b0, 12);
        frame_check(7'h00, 7'h6F, 7'h77);

        // Natural roll-over 10 -> 11 -> 0.
        drive(4'd10, 1'b0, 12);
        drive(4'd11, 1'b0, 12);
        drive(4'd0, 1'b0, 1);
        check("wrap_pulse", {7'b0, wrap}, 8'h01);
        check("pm_toggle", {7'b0, pm}, 8'h01);
        drive(4'd0, 1'b0, 1);
        check("wrap_one_cycle", {7'b0, wrap}, 8'h00);
        drive(4'd0, 1'b0, 10);
        frame_check(7'h06, 7'h5B, 7'h73);

        // Second roll-over returns to AM.
        drive(4'd11, 1'b0, 12);
        drive(4'd0, 1'b0, 1);
        check("wrap_pulse2", {7'b0, wrap}, 8'h01);
        check("pm_back_am", {7'b0, pm}, 8'h00);
        drive(4'd0, 1'b0, 11);

        // Load-induced 11 -> 0 is not a wrap.
        drive(4'd11, 1'b0, 11);
        drive(4'd11, 1'b1, 1);
        drive(4'd0, 1'b0, 1);
        check("load_no_wrap", {7'b0, wrap}, 8'h00);
        check("load_pm_keep", {7'b0, pm}, 8'h00);
        drive(4'd0, 1'b0, 1);
        check("load_no_wrap_late", {7'b0, wrap}, 8'h00);
        drive(4'd0, 1'b0, 10);

        // Out-of-range sample sets a sticky error.
        drive(4'd13, 1'b0, 1);
        check("err_set", {7'b0, err}, 8'h01);
        drive(4'd5, 1'b0, 11);
        check("err_sticky", {7'b0, err}, 8'h01);
        frame_check(7'h40, 7'h40, 7'h77);

        // Roll-over while in error still toggles pm; AP tracks it.
        drive(4'd11, 1'b0, 12);
        drive(4'd0, 1'b0, 1);
        check("err_wrap_pm", {7'b0, pm}, 8'h01);
        drive(4'd0, 1'b0, 5);
        check("pre_reset_ones_an", {5'b0, an}, 8'h02);
        check("pre_reset_ones_seg", {1'b0, seg}, 8'h40);

        // Reset mid-frame, away from the clock edge.
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        check("rst_mid_state", {6'b0, dbg_state}, 8'h00);
        @(negedge clk);
        check_reset_outputs("rst_mid_hold");
        rst = 1'b1;
        frame_check(7'h06, 7'h5B, 7'h77);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
